// File: rtl/instr_queue_pkg.sv
// Shared Tomasulo front-end types: the decoded control word and the default
// instruction queue depth.
package tomasula_types;

  localparam int IQ_DEPTH = 8;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [15:0] imm;
  } ctl_word;

endpackage

// File: rtl/instr_queue.sv
// Circular instruction queue between the instruction register and dispatch.
// Optional IQ_BYPASS_EN: an enqueue into an empty queue that is popped in the
// same cycle is forwarded straight to cw_o and never stored.
module instr_queue
  import tomasula_types::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic    clk,
  input  logic    rst,
  input  ctl_word control_word,
  input  logic    ld_iq,
  output logic    issue_q_full_n,
  output logic    ack_o,
  output ctl_word cw_o,
  output logic    valid_o,
  input  logic    deq_i,
  input  logic    flush_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  ctl_word       mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          ack_q, ack_d;

  logic stored_valid;
  logic enq_ok;
  logic bypass;
  logic push;
  logic pop;
  logic wr_en;

  always_comb begin
    // Fullness uses registered count only, so a same-cycle pop never frees a slot.
    issue_q_full_n = (count_q != CW'(DEPTH));
    stored_valid   = (count_q != '0);
    enq_ok         = ld_iq & issue_q_full_n;
`ifdef IQ_BYPASS_EN
    bypass         = enq_ok & deq_i & ~stored_valid;
`else
    bypass         = 1'b0;
`endif
    push           = enq_ok & ~bypass;
    pop            = deq_i & stored_valid;
    wr_en          = push & ~rst & ~flush_i;

    valid_o        = stored_valid | bypass;
    ack_o          = ack_q;
    if (stored_valid) begin
      cw_o = mem_q[head_q];
    end else if (bypass) begin
      cw_o = control_word;
    end else begin
      cw_o = '0;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ack_d   = 1'b0;
    if (rst || flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      ack_d = enq_ok;
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      if (push) begin
        tail_d = tail_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ack_q   <= ack_d;
    end
  end

  // Storage is deliberately not reset; count gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[tail_q] <= control_word;
    end
  end

endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of ctl_word entries (power of two, 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port control_word  input  tomasula_types::ctl_word  decoded word from the instruction register.
REQ-005 SHALL have port ld_iq  input  1  enqueue request from the instruction register.
REQ-006 SHALL have port issue_q_full_n  output  1  high when at least one entry is free.
REQ-007 SHALL have port ack_o  output  1  one-cycle pulse confirming the previous cycle's enqueue.
REQ-008 SHALL have port cw_o  output  tomasula_types::ctl_word  head entry presented to dispatch.
REQ-009 SHALL have port valid_o  output  1  high when cw_o holds a valid head entry.
REQ-010 SHALL have port deq_i  input  1  dispatch consumes the head this cycle.
REQ-011 SHALL have port flush_i  input  1  discard all entries (branch mispredict).

Function
REQ-012 SHALL implement a circular FIFO: head/tail pointers of $clog2(DEPTH) bits wrapping modulo DEPTH, plus a count of $clog2(DEPTH)+1 bits.
REQ-013 SHALL accept an enqueue when ld_iq=1 and issue_q_full_n=1 at the same edge; the word is written at tail, tail and count advance.
REQ-014 SHALL drive issue_q_full_n = (count != DEPTH) from registered count only; a same-cycle dequeue SHALL NOT free a slot for a same-cycle enqueue.
REQ-015 SHALL ignore ld_iq while full; no write, no ack_o.
REQ-016 SHALL register ack_o: ack_o=1 in the cycle after each accepted enqueue, else 0.
REQ-017 SHALL drive valid_o = (count != 0) and cw_o = entry at head, combinationally from registered state (enqueue-to-valid latency 1 cycle).
REQ-018 SHALL pop on deq_i=1 with valid_o=1; deq_i with valid_o=0 SHALL be ignored.
REQ-019 SHALL, on simultaneous accepted enqueue and pop, leave count unchanged and advance both pointers.
REQ-020 SHALL give flush_i priority over ld_iq and deq_i: pointers and count to 0, no write, ack_o=0 next cycle.
REQ-021 SHALL drive cw_o to all-zero when valid_o=0.

Reset
REQ-022 SHALL on rst=1 set head=tail=count=0, issue_q_full_n=1, ack_o=0, valid_o=0, cw_o=0 by the next edge.
REQ-023 SHALL treat rst mid-operation identically to flush, with rst taking priority over all inputs; entry storage contents need not be cleared.

Configuration
REQ-024 SHALL define macro IQ_BYPASS_EN: when defined, an enqueue accepted while count=0 and deq_i=1 in the same cycle SHALL pass control_word to cw_o with valid_o=1 that cycle and not be stored (count stays 0, ack_o still pulses next cycle).
REQ-025 SHALL, without IQ_BYPASS_EN, never assert valid_o when count=0 (minimum latency 1 cycle).

Structure
REQ-026 SHALL take ctl_word from tomasula_types; the DEPTH default SHALL live in the shared package as IQ_DEPTH.
REQ-027 SHALL be a single module with a flop-array storage; no sub-module.
REQ-028 SHALL connect to the instruction register through the existing IQ_SIG modport signals unchanged.

Verification
REQ-029 Reset then 3 enqueues (cw=A,B,C), deq_i=0 -> ack_o pulses each next cycle, count=3, valid_o=1, cw_o=A.
REQ-030 Fill DEPTH=8 entries, 9th ld_iq -> issue_q_full_n=0 after 8th, 9th ignored, no ack_o, head unchanged.
REQ-031 Full queue, ld_iq=1 and deq_i=1 same cycle -> pop occurs, enqueue rejected, count=7, issue_q_full_n=1 next cycle.
REQ-032 Count=4, ld_iq=1 and deq_i=1 repeated 20 cycles -> count stays 4, order preserved across pointer wrap.
REQ-033 Count=5, flush_i=1 with ld_iq=1 -> count=0, valid_o=0, issue_q_full_n=1, ack_o=0 next cycle.
REQ-034 IQ_BYPASS_EN defined, empty, ld_iq=1 cw=D, deq_i=1 -> cw_o=D, valid_o=1 same cycle, count stays 0; undefined -> valid_o=0 that cycle, cw_o=D next cycle.
